intc: RTL and testbench



---
 rtl/intc_pkg.sv | 34 +++
 rtl/intc_arbiter.sv | 29 ++
 rtl/intc.sv | 208 ++++++++++++++++++++
 tb/tb_intc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the external-interrupt controller: register map, source modes, bus helpers.
package lexington;

  localparam logic [31:0] INTC_PENDING   = 32'h0000_0000;
  localparam logic [31:0] INTC_ENABLE    = 32'h0000_0001;
  localparam logic [31:0] INTC_MODE      = 32'h0000_0002;
  localparam logic [31:0] INTC_THRESHOLD = 32'h0000_0003;
  localparam logic [31:0] INTC_CLAIM     = 32'h0000_0004;
  localparam logic [31:0] INTC_PRIO_BASE = 32'h0000_0008;

  localparam logic [31:0] DEFAULT_INTC_BASE_ADDR = 32'h1000_0000;

  typedef enum logic {
    LEVEL = 1'b0,
    EDGE  = 1'b1
  } intc_mode_t;

  // Merge a bus write into an existing word, byte by byte.
  function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_val[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_val[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/intc_arbiter.sv
// Combinational winner selection: highest priority wins, ties resolved towards the lowest ID.
import lexington::*;

module intc_arbiter #(
  parameter int NUM_IRQ    = 16,
  parameter int PRIO_WIDTH = 3
) (
  input  logic [NUM_IRQ-1:0]            candidates,
  input  logic [NUM_IRQ*PRIO_WIDTH-1:0] prio,
  output logic [4:0]                    winner_id,
  output logic [PRIO_WIDTH-1:0]         winner_prio
);

  // Ascending scan with strict compare keeps the lowest ID on equal priority.
  always_comb begin
    winner_id   = 5'd0;
    winner_prio = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (candidates[i] && (prio[i*PRIO_WIDTH +: PRIO_WIDTH] > winner_prio)) begin
        winner_id   = 5'(i + 1);
        winner_prio = prio[i*PRIO_WIDTH +: PRIO_WIDTH];
      end else begin
        winner_id   = winner_id;
        winner_prio = winner_prio;
      end
    end
  end

endmodule

// File: rtl/intc.sv
// External-interrupt controller with claim/complete and threshold gating.
// IRQ_SYNC_EN adds a two-flop synchroniser ahead of the sampling register for asynchronous sources.
import lexington::*;

module intc #(
  parameter int NUM_IRQ    = 16,
  parameter int PRIO_WIDTH = 3,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IRQ-1:0]    irq_src,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strobe,
  output logic [31:0]           rd_data,
  output logic                  ext_interrupt,
  output logic [4:0]            irq_id
);

  localparam logic [31:0] IRQ_MASK = 32'((64'd1 << NUM_IRQ) - 64'd1);
  localparam int          PW       = PRIO_WIDTH;

  logic [NUM_IRQ-1:0]    s_in_s, s_q, s_prev_q, rise_s;
  logic [NUM_IRQ-1:0]    pending_q, pending_d;
  logic [NUM_IRQ-1:0]    enable_q, enable_d;
  logic [NUM_IRQ-1:0]    mode_q, mode_d;
  logic [NUM_IRQ-1:0]    in_service_q, in_service_d;
  logic [NUM_IRQ-1:0]    candidates_s, claim_hit_s, complete_hit_s, w1c_s;
  logic [PW-1:0]         threshold_q, threshold_d;
  logic [NUM_IRQ*PW-1:0] prio_q, prio_d;
  logic                  ext_interrupt_q, ext_interrupt_d;
  logic [4:0]            irq_id_q, irq_id_d;
  logic [4:0]            winner_id_s;
  logic [PW-1:0]         winner_prio_s;
  logic [31:0]           addr_w_s, enable_wr_s, mode_wr_s, pend_wr_s;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for sources outside clk's domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end
  assign s_in_s = sync2_q;
`else
  assign s_in_s = irq_src;
`endif

  assign addr_w_s    = 32'(addr);
  assign rise_s      = s_q & ~s_prev_q;
  assign enable_wr_s = apply_strobe(32'(enable_q), wr_data, wr_strobe) & IRQ_MASK;
  assign mode_wr_s   = apply_strobe(32'(mode_q), wr_data, wr_strobe) & IRQ_MASK;
  assign pend_wr_s   = apply_strobe(32'd0, wr_data, wr_strobe) & IRQ_MASK;

  // A source competes only while pending, enabled, not in service and with nonzero priority.
  always_comb begin
    candidates_s = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      candidates_s[i] = pending_q[i] & enable_q[i] & ~in_service_q[i] &
                        (prio_q[i*PW +: PW] != '0);
    end
  end

  intc_arbiter #(
    .NUM_IRQ    (NUM_IRQ),
    .PRIO_WIDTH (PRIO_WIDTH)
  ) u_arbiter (
    .candidates  (candidates_s),
    .prio        (prio_q),
    .winner_id   (winner_id_s),
    .winner_prio (winner_prio_s)
  );

  // Configuration register writes; priority and threshold live in byte 0.
  always_comb begin
    enable_d    = enable_q;
    mode_d      = mode_q;
    threshold_d = threshold_q;
    prio_d      = prio_q;
    if (wr_en && (addr_w_s == INTC_ENABLE)) begin
      enable_d = enable_wr_s[NUM_IRQ-1:0];
    end else begin
      enable_d = enable_q;
    end
    if (wr_en && (addr_w_s == INTC_MODE)) begin
      mode_d = mode_wr_s[NUM_IRQ-1:0];
    end else begin
      mode_d = mode_q;
    end
    if (wr_en && (addr_w_s == INTC_THRESHOLD) && wr_strobe[0]) begin
      threshold_d = wr_data[PW-1:0];
    end else begin
      threshold_d = threshold_q;
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (wr_en && wr_strobe[0] && (addr_w_s == INTC_PRIO_BASE + 32'(i))) begin
        prio_d[i*PW +: PW] = wr_data[PW-1:0];
      end else begin
        prio_d[i*PW +: PW] = prio_q[i*PW +: PW];
      end
    end
  end

  // Claim, complete and W1C decoded into per-source strobes.
  always_comb begin
    claim_hit_s    = '0;
    complete_hit_s = '0;
    w1c_s          = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      claim_hit_s[i]    = rd_en && (addr_w_s == INTC_CLAIM) && (winner_id_s == 5'(i + 1));
      complete_hit_s[i] = wr_en && wr_strobe[0] && (addr_w_s == INTC_CLAIM) &&
                          (wr_data[4:0] == 5'(i + 1));
      if (wr_en && (addr_w_s == INTC_PENDING)) begin
        w1c_s[i] = pend_wr_s[i];
      end else begin
        w1c_s[i] = 1'b0;
      end
    end
  end

  // Pending and in-service update; a fresh edge outranks any clear in the same cycle.
  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      in_service_d[i] = (in_service_q[i] & ~complete_hit_s[i]) | claim_hit_s[i];
      if (mode_d[i] != mode_q[i]) begin
        pending_d[i] = 1'b0;
      end else if (intc_mode_t'(mode_q[i]) == EDGE) begin
        pending_d[i] = rise_s[i] | (pending_q[i] & ~(claim_hit_s[i] | w1c_s[i]));
      end else begin
        pending_d[i] = s_q[i];
      end
    end
  end

  // Interrupt request and winner ID are registered from the current arbitration.
  always_comb begin
    ext_interrupt_d = (winner_id_s != 5'd0) && (winner_prio_s > threshold_q);
    irq_id_d        = winner_id_s;
  end

  // Read mux reflects pre-write state, so simultaneous read+write returns old values.
  always_comb begin
    rd_data = 32'd0;
    if (rd_en) begin
      case (addr_w_s)
        INTC_PENDING:   rd_data = 32'(pending_q);
        INTC_ENABLE:    rd_data = 32'(enable_q);
        INTC_MODE:      rd_data = 32'(mode_q);
        INTC_THRESHOLD: rd_data = 32'(threshold_q);
        INTC_CLAIM:     rd_data = 32'(winner_id_s);
        default: begin
          rd_data = 32'd0;
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (addr_w_s == INTC_PRIO_BASE + 32'(i)) begin
              rd_data = 32'(prio_q[i*PW +: PW]);
            end else begin
              rd_data = rd_data;
            end
          end
        end
      endcase
    end else begin
      rd_data = 32'd0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q             <= '0;
      s_prev_q        <= '0;
      pending_q       <= '0;
      enable_q        <= '0;
      mode_q          <= '0;
      in_service_q    <= '0;
      threshold_q     <= '0;
      prio_q          <= '0;
      ext_interrupt_q <= 1'b0;
      irq_id_q        <= 5'd0;
    end else begin
      s_q             <= s_in_s;
      s_prev_q        <= s_q;
      pending_q       <= pending_d;
      enable_q        <= enable_d;
      mode_q          <= mode_d;
      in_service_q    <= in_service_d;
      threshold_q     <= threshold_d;
      prio_q          <= prio_d;
      ext_interrupt_q <= ext_interrupt_d;
      irq_id_q        <= irq_id_d;
    end
  end

  assign ext_interrupt = ext_interrupt_q;
  assign irq_id        = irq_id_q;

endmodule

// File: tb/tb_intc.sv
// Directed self-checking bench for intc with hand-computed expectations.
module tb_intc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] irq_src = 16'd0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  addr = 6'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_strobe = 4'd0;
  logic [31:0] rd_data;
  logic        ext_interrupt;
  logic [4:0]  irq_id;

  int total = 0;
  int bad   = 0;

  intc dut (
    .clk           (clk),
    .rst           (rst),
    .irq_src       (irq_src),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .wr_strobe     (wr_strobe),
    .rd_data       (rd_data),
    .ext_interrupt (ext_interrupt),
    .irq_id        (irq_id)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wr_data = d; wr_strobe = s; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; wr_strobe = 4'd0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    #1 d = rd_data;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    cycles(3);
    total++; if (ext_interrupt !== 1'b0) begin bad++; $display("FAIL reset_ext got=%b exp=0", ext_interrupt); end
    total++; if (irq_id !== 5'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    rst = 1'b0;
    bus_read(6'h01, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_enable got=%h exp=0", d); end
    bus_read(6'h04, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_claim got=%h exp=0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_write(6'h01, 32'hFFFF_FFFF, 4'hF);
    bus_read(6'h01, d);
    total++; if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL enable_mask got=%h exp=0000ffff", d); end
    bus_write(6'h01, 32'hABCD_1234, 4'h1);
    bus_read(6'h01, d);
    total++; if (d !== 32'h0000_FF34) begin bad++; $display("FAIL enable_strobe got=%h exp=0000ff34", d); end
    addr = 6'h01; #1;
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rd_idle got=%h exp=0", rd_data); end
    @(negedge clk);
    bus_write(6'h30, 32'h5A, 4'hF);
    bus_read(6'h30, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped got=%h exp=0", d); end
    bus_write(6'h08, 32'h0F, 4'hF);
    bus_read(6'h08, d);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL prio_width got=%h exp=7", d); end
    bus_write(6'h08, 32'h0, 4'hF);
    bus_write(6'h01, 32'h0, 4'hF);
  endtask

  task automatic test_edge_latency();
    logic [31:0] d;
    bus_write(6'h02, 32'h4, 4'hF);
    bus_write(6'h0A, 32'h2, 4'hF);
    bus_write(6'h03, 32'h0, 4'hF);
    bus_write(6'h01, 32'h4, 4'hF);
    irq_src[2] = 1'b1;
    @(negedge clk);
    irq_src[2] = 1'b0;
    total++; if (ext_interrupt !== 1'b0) begin bad++; $display("FAIL lat_early1 got=%b exp=0", ext_interrupt); end
    @(negedge clk);
    total++; if (ext_interrupt !== 1'b0) begin bad++; $display("FAIL lat_early2 got=%b exp=0", ext_interrupt); end
    @(negedge clk);
    total++; if (ext_interrupt !== 1'b1) begin bad++; $display("FAIL lat_ext got=%b exp=1", ext_interrupt); end
    total++; if (irq_id !== 5'd3) begin bad++; $display("FAIL lat_id got=%0d exp=3", irq_id); end
    bus_read(6'h04, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL lat_claim got=%0d exp=3", d); end
    bus_read(6'h00, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL lat_pend_clr got=%h exp=0", d); end
    total++; if (ext_interrupt !== 1'b0) begin bad++; $display("FAIL lat_ext_drop got=%b exp=0", ext_interrupt); end
    bus_write(6'h04, 32'd3, 4'hF);
    bus_write(6'h01, 32'h0, 4'hF);
  endtask

  task automatic test_priority_tie();
    logic [31:0] d;
    logic [31:0] exp_ids [4];
    exp_ids[0] = 32'd7; exp_ids[1] = 32'd2; exp_ids[2] = 32'd5; exp_ids[3] = 32'd0;
    bus_write(6'h02, 32'h52, 4'hF);
    bus_write(6'h09, 32'h4, 4'hF);
    bus_write(6'h0C, 32'h4, 4'hF);
    bus_write(6'h0E, 32'h6, 4'hF);
    bus_write(6'h01, 32'h52, 4'hF);
    irq_src = 16'h0052;
    @(negedge clk);
    irq_src = 16'h0000;
    cycles(3);
    for (int k = 0; k < 4; k++) begin
      bus_read(6'h04, d);
      total++; if (d !== exp_ids[k]) begin bad++; $display("FAIL prio_claim%0d got=%0d exp=%0d", k, d, exp_ids[k]); end
    end
    bus_write(6'h04, 32'd7, 4'hF);
    bus_write(6'h04, 32'd2, 4'hF);
    bus_write(6'h04, 32'd5, 4'hF);
    bus_write(6'h01, 32'h0, 4'hF);
  endtask

  task automatic test_threshold();
    bus_write(6'h02, 32'h0, 4'hF);
    bus_write(6'h0D, 32'h3, 4'hF);
    bus_write(6'h03, 32'h3, 4'hF);
    bus_write(6'h01, 32'h20, 4'hF);
    irq_src[5] = 1'b1;
    cycles(4);
    total++; if (ext_interrupt !== 1'b0) begin bad++; $display("FAIL thr_equal got=%b exp=0", ext_interrupt); end
    total++; if (irq_id !== 5'd6) begin bad++; $display("FAIL thr_id got=%0d exp=6", irq_id); end
    bus_write(6'h03, 32'h2, 4'hF);
    @(negedge clk);
    total++; if (ext_interrupt !== 1'b1) begin bad++; $display("FAIL thr_below got=%b exp=1", ext_interrupt); end
    irq_src[5] = 1'b0;
    bus_write(6'h01, 32'h0, 4'hF);
    bus_write(6'h03, 32'h0, 4'hF);
    cycles(3);
  endtask

  task automatic test_level_mask();
    logic [31:0] d;
    bus_write(6'h08, 32'h5, 4'hF);
    bus_write(6'h01, 32'h1, 4'hF);
    irq_src[0] = 1'b1;
    cycles(4);
    total++; if (ext_interrupt !== 1'b1) begin bad++; $display("FAIL lvl_ext got=%b exp=1", ext_interrupt); end
    bus_read(6'h04, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL lvl_claim got=%0d exp=1", d); end
    cycles(1);
    total++; if (ext_interrupt !== 1'b0) begin bad++; $display("FAIL lvl_masked got=%b exp=0", ext_interrupt); end
    bus_write(6'h04, 32'd0, 4'hF);
    cycles(1);
    total++; if (ext_interrupt !== 1'b0) begin bad++; $display("FAIL lvl_cmp0 got=%b exp=0", ext_interrupt); end
    bus_write(6'h04, 32'd9, 4'hF);
    cycles(1);
    total++; if (ext_interrupt !== 1'b0) begin bad++; $display("FAIL lvl_cmp9 got=%b exp=0", ext_interrupt); end
    bus_write(6'h04, 32'd1, 4'hF);
    cycles(1);
    total++; if (ext_interrupt !== 1'b1) begin bad++; $display("FAIL lvl_cmp1 got=%b exp=1", ext_interrupt); end
    irq_src[0] = 1'b0;
    bus_write(6'h01, 32'h0, 4'hF);
    cycles(3);
  endtask

  task automatic test_edge_during_claim();
    logic [31:0] d;
    bus_write(6'h02, 32'h8, 4'hF);
    bus_write(6'h0B, 32'h1, 4'hF);
    bus_write(6'h01, 32'h8, 4'hF);
    irq_src[3] = 1'b1;
    @(negedge clk);
    irq_src[3] = 1'b0;
    cycles(3);
    bus_read(6'h00, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL edc_pend got=%h exp=8", d); end
    irq_src[3] = 1'b1;
    @(negedge clk);
    irq_src[3] = 1'b0;
    bus_read(6'h04, d);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL edc_claim got=%0d exp=4", d); end
    bus_read(6'h00, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL edc_kept got=%h exp=8", d); end
    bus_read(6'h04, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL edc_insvc got=%0d exp=0", d); end
    bus_write(6'h00, 32'h8, 4'hF);
    bus_read(6'h00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL edc_w1c got=%h exp=0", d); end
    bus_write(6'h04, 32'd4, 4'hF);
    bus_write(6'h01, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid_claim();
    logic [31:0] d;
    bus_write(6'h02, 32'h0, 4'hF);
    bus_write(6'h01, 32'h1, 4'hF);
    irq_src[0] = 1'b1;
    cycles(4);
    bus_read(6'h04, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL rmc_claim got=%0d exp=1", d); end
    addr = 6'h04; rd_en = 1'b1; rst = 1'b1;
    @(negedge clk);
    total++; if (ext_interrupt !== 1'b0) begin bad++; $display("FAIL rmc_ext got=%b exp=0", ext_interrupt); end
    total++; if (irq_id !== 5'd0) begin bad++; $display("FAIL rmc_id got=%0d exp=0", irq_id); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rmc_claimrd got=%h exp=0", rd_data); end
    addr = 6'h01; #1;
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rmc_enable got=%h exp=0", rd_data); end
    addr = 6'h08; #1;
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rmc_prio got=%h exp=0", rd_data); end
    @(negedge clk);
    rd_en = 1'b0; irq_src = 16'd0; rst = 1'b0;
    bus_read(6'h00, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rmc_pend got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_edge_latency();
    test_priority_tie();
    test_threshold();
    test_level_mask();
    test_edge_during_claim();
    test_reset_mid_claim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
